// File: rtl/i2s_frame_scheduler.sv
// i2s_frame_scheduler
//   Moves one mono sample per I2S frame from the receiver, through the DSP
//   pipeline, and into the transmitter sample register, all in the clk domain.
//   A per-frame deadline aborts frames the DSP cannot finish in time.
//   Build option: define I2S_SCHED_MUTE_ON_OVERRUN_EN to force tx_sample to zero
//   (with a tx_update pulse) whenever a frame is aborted; by default the
//   previous tx_sample is held and no update is signalled.
module i2s_frame_scheduler #(
  parameter int DATA_WIDTH      = 24,
  parameter int SYNC_STAGES     = 2,
  parameter int DEADLINE_CYCLES = 1000,
  parameter int OVR_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  lrclk_in,
  input  logic [DATA_WIDTH-1:0] rx_sample,
  output logic [DATA_WIDTH-1:0] dsp_in_data,
  output logic                  dsp_in_valid,
  input  logic                  dsp_in_ready,
  input  logic [DATA_WIDTH-1:0] dsp_out_data,
  input  logic                  dsp_out_valid,
  output logic                  dsp_out_ready,
  output logic                  dsp_flush,
  output logic [DATA_WIDTH-1:0] tx_sample,
  output logic                  tx_update,
  output logic                  frame_tick,
  output logic                  busy,
  output logic [OVR_WIDTH-1:0]  overrun_count
);

  // Deadline counter must be able to hold DEADLINE_CYCLES-1 and one beyond.
  localparam int CNT_W = $clog2(DEADLINE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DL_LAST = CNT_W'(DEADLINE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  // Saturating increment for the overrun counter: sticks at all-ones.
  function automatic logic [OVR_WIDTH-1:0] sat_inc(input logic [OVR_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end
    return v + OVR_WIDTH'(1);
  endfunction

  // Synchroniser and edge detector.
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lr_prev_q, lr_prev_d;
  logic                   frame_tick_q, frame_tick_d;

  // Frame sequencing.
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       dl_cnt_q, dl_cnt_d;
  logic [OVR_WIDTH-1:0]   ovr_q, ovr_d;

  // Sample registers.
  logic [DATA_WIDTH-1:0]  dsp_in_data_q, dsp_in_data_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic [DATA_WIDTH-1:0]  tx_sample_q, tx_sample_d;
  logic                   tx_update_q, tx_update_d;

  // Per-cycle decision terms.
  logic                   in_flight;
  logic                   result_now;
  logic                   deadline_hit;

  // Shift lrclk through the synchroniser; the tick is registered once more so
  // it appears SYNC_STAGES+1 clocks after the lrclk_in rising edge.
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], lrclk_in};
    lr_prev_d    = sync_q[SYNC_STAGES-1];
    frame_tick_d = sync_q[SYNC_STAGES-1] & ~lr_prev_q;
  end

  // Next-state, sample capture, abort handling and handshake outputs.
  always_comb begin
    state_d       = state_q;
    dl_cnt_d      = dl_cnt_q;
    ovr_d         = ovr_q;
    dsp_in_data_d = dsp_in_data_q;
    result_d      = result_q;
    tx_sample_d   = tx_sample_q;
    tx_update_d   = 1'b0;
    dsp_in_valid  = 1'b0;
    dsp_out_ready = 1'b0;
    dsp_flush     = 1'b0;

    in_flight    = (state_q == S_ISSUE) || (state_q == S_WAIT);
    // A result arriving on the last allowed cycle still counts as on time.
    result_now   = (state_q == S_WAIT) && dsp_out_valid;
    deadline_hit = in_flight && (dl_cnt_q == DL_LAST) && !result_now;

    // Counter holds clocks elapsed since the frame tick (tick cycle = 0).
    if (state_q != S_IDLE) begin
      dl_cnt_d = dl_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_ISSUE: begin
        dsp_in_valid = 1'b1;
        if (dsp_in_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        dsp_out_ready = 1'b1;
        if (dsp_out_valid) begin
          result_d = dsp_out_data;
          state_d  = S_COMMIT;
        end
      end
      S_COMMIT: begin
        // The result is already in hand, so commit is never aborted.
        tx_sample_d = result_q;
        tx_update_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (in_flight && !enable) begin
      // Leaving DSP mode is a deliberate stop, not an overrun.
      dsp_flush = 1'b1;
      state_d   = S_IDLE;
    end else if (in_flight && (frame_tick_q || deadline_hit)) begin
      // Tick and deadline together are a single abort.
      dsp_flush = 1'b1;
      ovr_d     = sat_inc(ovr_q);
      state_d   = S_IDLE;
`ifdef I2S_SCHED_MUTE_ON_OVERRUN_EN
      tx_sample_d = '0;
      tx_update_d = 1'b1;
`else
      tx_sample_d = tx_sample_q;
`endif
    end

    // A tick always starts the new frame, after any abort above.
    if (frame_tick_q) begin
      if (enable) begin
        dsp_in_data_d = rx_sample;
        dl_cnt_d      = CNT_W'(1);
        state_d       = S_ISSUE;
      end else begin
        tx_sample_d = rx_sample;
        tx_update_d = 1'b1;
      end
    end
  end

  // Control and output registers; async reset returns everything to zero/IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q        <= '0;
      lr_prev_q     <= 1'b0;
      frame_tick_q  <= 1'b0;
      state_q       <= S_IDLE;
      dl_cnt_q      <= '0;
      ovr_q         <= '0;
      dsp_in_data_q <= '0;
      tx_sample_q   <= '0;
      tx_update_q   <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      lr_prev_q     <= lr_prev_d;
      frame_tick_q  <= frame_tick_d;
      state_q       <= state_d;
      dl_cnt_q      <= dl_cnt_d;
      ovr_q         <= ovr_d;
      dsp_in_data_q <= dsp_in_data_d;
      tx_sample_q   <= tx_sample_d;
      tx_update_q   <= tx_update_d;
    end
  end

  // DSP result holding register; only read in COMMIT, so it needs no reset.
  always_ff @(posedge clk) begin
    result_q <= result_d;
  end

  assign dsp_in_data   = dsp_in_data_q;
  assign tx_sample     = tx_sample_q;
  assign tx_update     = tx_update_q;
  assign frame_tick    = frame_tick_q;
  assign busy          = (state_q != S_IDLE);
  assign overrun_count = ovr_q;

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Bench for i2s_frame_scheduler: table of frames plus hand-written corner
// sequences; tx_sample updates are checked against a queue of expected values.
`timescale 1ns/1ps
module tb_i2s_frame_scheduler;

  localparam int DW   = 24;
  localparam int SYNC = 2;
  localparam int DL   = 50;
  localparam int OW   = 2;
`ifdef I2S_SCHED_MUTE_ON_OVERRUN_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  typedef struct {
    logic          en;
    logic [DW-1:0] rx;
    logic [DW-1:0] res;
    int            lat;       // DSP answer delay after entering WAIT; <0 = never
    logic          commit;    // expect a tx_update carrying exp_tx
    logic [DW-1:0] exp_tx;
    int            flush_at;  // clocks after tick of dsp_flush; 0 = none
    int            ovr_inc;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          lrclk_in;
  logic [DW-1:0] rx_sample;
  logic [DW-1:0] dsp_in_data;
  logic          dsp_in_valid;
  logic          dsp_in_ready;
  logic [DW-1:0] dsp_out_data;
  logic          dsp_out_valid;
  logic          dsp_out_ready;
  logic          dsp_flush;
  logic [DW-1:0] tx_sample;
  logic          tx_update;
  logic          frame_tick;
  logic          busy;
  logic [OW-1:0] overrun_count;

  int errors = 0;
  int checks = 0;
  int tick_seen = 0;
  int exp_ticks = 0;
  int overlap = 0;
  int in_valid_seen = 0;
  int exp_ovr = 0;
  logic [DW-1:0] exp_hold = '0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_tmp;
  vec_t vecs[7];
  vec_t never_v;
  vec_t byp_v;

  i2s_frame_scheduler #(
    .DATA_WIDTH(DW), .SYNC_STAGES(SYNC), .DEADLINE_CYCLES(DL), .OVR_WIDTH(OW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .lrclk_in(lrclk_in),
    .rx_sample(rx_sample), .dsp_in_data(dsp_in_data), .dsp_in_valid(dsp_in_valid),
    .dsp_in_ready(dsp_in_ready), .dsp_out_data(dsp_out_data),
    .dsp_out_valid(dsp_out_valid), .dsp_out_ready(dsp_out_ready),
    .dsp_flush(dsp_flush), .tx_sample(tx_sample), .tx_update(tx_update),
    .frame_tick(frame_tick), .busy(busy), .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard and protocol monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_update) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx_update: got tx_sample=%0h with nothing expected", tx_sample);
        end else begin
          exp_tmp = exp_q.pop_front();
          chk("tx_sample_update", tx_sample, exp_tmp);
        end
      end
      if (frame_tick) tick_seen++;
      if (dsp_in_valid && dsp_out_ready) overlap++;
      if (dsp_in_valid) in_valid_seen++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Call right after raising lrclk_in at a negedge.
  task automatic wait_tick(input string tag);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!frame_tick && lat < 10);
    chk({tag, "_tick_latency"}, lat, 3);
    exp_ticks++;
  endtask

  task automatic bump_ovr();
    if (exp_ovr < (1 << OW) - 1) exp_ovr++;
  endtask

  task automatic lr_low();
    lrclk_in      = 1'b0;
    dsp_in_ready  = 1'b0;
    dsp_out_valid = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int  cyc, phase, fl_at, ivs0;
    bit  done, data_ok;
    @(negedge clk);
    enable    = v.en;
    rx_sample = v.rx;
    if (v.commit) begin
      exp_q.push_back(v.exp_tx);
      exp_hold = v.exp_tx;
    end else if (MUTE && v.ovr_inc != 0) begin
      exp_q.push_back('0);
      exp_hold = '0;
    end
    if (v.ovr_inc != 0) bump_ovr();
    ivs0     = in_valid_seen;
    lrclk_in = 1'b1;
    wait_tick(tag);
    cyc = 0; phase = 0; fl_at = 0; done = 0; data_ok = 1;
    while (!done && cyc < 120) begin
      @(negedge clk);
      cyc++;
      case (phase)
        0: if (dsp_in_valid) begin
             if (dsp_in_data !== v.rx) data_ok = 0;
             dsp_in_ready = 1'b1;
             phase = 1;
           end
        1: begin
             dsp_in_ready = 1'b0;
             if (v.lat >= 0 && cyc >= 2 + v.lat) begin
               dsp_out_valid = 1'b1;
               dsp_out_data  = v.res;
               phase = 2;
             end
           end
        default: dsp_out_valid = 1'b0;
      endcase
      #1;
      if (dsp_flush && fl_at == 0) begin
        fl_at = cyc;
        done  = 1;
      end
      if (tx_update) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no tx_update or flush within %0d clocks", tag, cyc);
    end
    dsp_in_ready  = 1'b0;
    dsp_out_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_flush_at"}, fl_at, v.flush_at);
    chk({tag, "_overrun"}, overrun_count, exp_ovr);
    chk({tag, "_tx_hold"}, tx_sample, exp_hold);
    chk({tag, "_pending"}, exp_q.size(), 0);
    if (v.en) begin
      chk({tag, "_issued"}, (phase != 0), 1);
      chk({tag, "_in_data"}, data_ok, 1);
    end else begin
      chk({tag, "_no_issue"}, in_valid_seen - ivs0, 0);
    end
    lr_low();
  endtask

  initial begin
    vecs[0] = '{en:1'b1, rx:24'h123456, res:24'h654321, lat:10, commit:1'b1, exp_tx:24'h654321, flush_at:0,    ovr_inc:0};
    vecs[1] = '{en:1'b1, rx:24'h000001, res:24'h7FFFFF, lat:0,  commit:1'b1, exp_tx:24'h7FFFFF, flush_at:0,    ovr_inc:0};
    vecs[2] = '{en:1'b0, rx:24'hABCDEF, res:24'h000000, lat:0,  commit:1'b1, exp_tx:24'hABCDEF, flush_at:0,    ovr_inc:0};
    vecs[3] = '{en:1'b1, rx:24'h800000, res:24'h800001, lat:47, commit:1'b1, exp_tx:24'h800001, flush_at:0,    ovr_inc:0};
    vecs[4] = '{en:1'b1, rx:24'h111111, res:24'h000000, lat:-1, commit:1'b0, exp_tx:24'h000000, flush_at:DL-1, ovr_inc:1};
    vecs[5] = '{en:1'b0, rx:24'hFFFFFF, res:24'h000000, lat:0,  commit:1'b1, exp_tx:24'hFFFFFF, flush_at:0,    ovr_inc:0};
    vecs[6] = '{en:1'b1, rx:24'h0ABCDE, res:24'h000000, lat:3,  commit:1'b1, exp_tx:24'h000000, flush_at:0,    ovr_inc:0};
    never_v = '{en:1'b1, rx:24'h222222, res:24'h000000, lat:-1, commit:1'b0, exp_tx:24'h000000, flush_at:DL-1, ovr_inc:1};
    byp_v   = '{en:1'b0, rx:24'hC0FFEE, res:24'h000000, lat:0,  commit:1'b1, exp_tx:24'hC0FFEE, flush_at:0,    ovr_inc:0};

    reset = 1'b1; enable = 1'b0; lrclk_in = 1'b0; rx_sample = '0;
    dsp_in_ready = 1'b0; dsp_out_valid = 1'b0; dsp_out_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_sample", tx_sample, 0);
    chk("rst_tx_update", tx_update, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun_count, 0);
    chk("rst_in_valid", dsp_in_valid, 0);
    chk("rst_flush", dsp_flush, 0);
    chk("rst_frame_tick", frame_tick, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) run_frame(vecs[i], $sformatf("v%0d", i));

    // Second lrclk rise while the DSP still owes a result.
    @(negedge clk);
    enable = 1'b1; rx_sample = 24'h0A0A0A; lrclk_in = 1'b1;
    wait_tick("b2b_a");
    @(negedge clk); dsp_in_ready = 1'b1;
    @(negedge clk); dsp_in_ready = 1'b0; lrclk_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_sample = 24'hB0B0B0; lrclk_in = 1'b1;
    if (MUTE) begin
      exp_q.push_back('0);
      exp_hold = '0;
    end
    bump_ovr();
    wait_tick("b2b_b");
    #1 chk("b2b_flush", dsp_flush, 1);
    @(negedge clk); #1;
    chk("b2b_issue_valid", dsp_in_valid, 1);
    chk("b2b_in_data", dsp_in_data, 24'hB0B0B0);
    chk("b2b_overrun", overrun_count, exp_ovr);
    chk("b2b_busy", busy, 1);
    dsp_in_ready = 1'b1;
    @(negedge clk);
    dsp_in_ready = 1'b0;
    exp_q.push_back(24'h0B0B0B);
    exp_hold = 24'h0B0B0B;
    dsp_out_valid = 1'b1; dsp_out_data = 24'h0B0B0B;
    @(negedge clk);
    dsp_out_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_pending", exp_q.size(), 0);
    chk("b2b_tx", tx_sample, exp_hold);
    lr_low();

    // enable drops while the frame is in flight.
    @(negedge clk);
    enable = 1'b1; rx_sample = 24'h00C0DE; lrclk_in = 1'b1;
    wait_tick("enfall");
    @(negedge clk); dsp_in_ready = 1'b1;
    @(negedge clk); dsp_in_ready = 1'b0; enable = 1'b0;
    #1 chk("enfall_flush", dsp_flush, 1);
    @(negedge clk); #1;
    chk("enfall_busy", busy, 0);
    chk("enfall_overrun", overrun_count, exp_ovr);
    chk("enfall_tx", tx_sample, exp_hold);
    lr_low();

    // Overrun counter saturation.
    for (int k = 0; k < 5; k++) run_frame(never_v, $sformatf("sat%0d", k));
    chk("sat_final", overrun_count, 2'b11);

    // Async reset in the middle of WAIT.
    @(negedge clk);
    enable = 1'b1; rx_sample = 24'h5A5A5A; lrclk_in = 1'b1;
    wait_tick("rstw");
    @(negedge clk); dsp_in_ready = 1'b1;
    @(negedge clk); dsp_in_ready = 1'b0;
    #1 chk("rstw_in_wait", dsp_out_ready, 1);
    #2 reset = 1'b1; lrclk_in = 1'b0;
    #1;
    chk("rstw_busy", busy, 0);
    chk("rstw_out_ready", dsp_out_ready, 0);
    chk("rstw_flush", dsp_flush, 0);
    chk("rstw_tx_sample", tx_sample, 0);
    chk("rstw_in_data", dsp_in_data, 0);
    chk("rstw_overrun", overrun_count, 0);
    exp_ovr = 0;
    exp_hold = '0;
    @(negedge clk);
    chk("rstw_busy_next", busy, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_frame(byp_v, "post_rst");

    chk("tick_count", tick_seen, exp_ticks);
    chk("valid_ready_overlap", overlap, 0);
    chk("final_pending", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
